// File: rtl/solver_sequencer_pkg.sv
// solver_sequencer_pkg: shared types and constants for the solver run controller.
package solver_sequencer_pkg;
    localparam int ANSWER_BITS   = 48;
    localparam int ROM_ADDR_BITS = 16;
    typedef logic [ROM_ADDR_BITS-1:0] rom_addr_t;
    typedef enum logic [2:0] {
        S_IDLE,
        S_RELEASE,
        S_RUN,
        S_GAP,
        S_DONE,
        S_ERROR
    } seq_fsm_e;
    typedef enum logic [1:0] {
        ERR_NONE,
        ERR_SOLVER,
        ERR_TIMEOUT,
        ERR_ABORT
    } seq_err_e;
endpackage

// File: rtl/solver_sequencer_if.sv
// solver_sequencer_if: shared ROM port and solver array control/status bundle.
interface solver_sequencer_if
    import solver_sequencer_pkg::*;
#(
    parameter int NUM_SOLVERS = 2
);
    rom_addr_t                                   rom_addr;
    logic [7:0]                                  rom_data;
    logic [NUM_SOLVERS-1:0]                      solver_rst_n;
    rom_addr_t [NUM_SOLVERS-1:0]                 solver_addr;
    logic [NUM_SOLVERS-1:0]                      solver_done;
    logic [NUM_SOLVERS-1:0]                      solver_error;
    logic [NUM_SOLVERS-1:0][ANSWER_BITS-1:0]     solver_answer;
    modport master (
        output rom_addr, solver_rst_n,
        input  solver_addr, solver_done, solver_error, solver_answer
    );
    modport slave (
        input  rom_addr, rom_data, solver_rst_n,
        output solver_addr, solver_done, solver_error, solver_answer
    );
endinterface

// File: rtl/solver_sequencer_watchdog.sv
// solver_sequencer_watchdog: saturating run-time counter with clear, enable and expiry flag.
module solver_sequencer_watchdog #(
    parameter int TIMEOUT_CYCLES = 2**20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [W-1:0] count;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count <= '0;
        else if (clear) count <= '0;
        else if (enable && !(&count)) count <= count + W'(1);
    end
    assign expired = count == W'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/solver_sequencer.sv
// solver_sequencer: runs solvers one at a time on a shared ROM port, capturing answers under a watchdog.
module solver_sequencer
    import solver_sequencer_pkg::*;
#(
    parameter int NUM_SOLVERS    = 2,
    parameter int TIMEOUT_CYCLES = 2**20,
    parameter int CYCLE_BITS     = 32,
    localparam int IDX_BITS      = NUM_SOLVERS > 1 ? $clog2(NUM_SOLVERS) : 1
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   start,
    input  logic                                   abort,
    solver_sequencer_if.master                     bus,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   error,
    output logic [1:0]                             err_code,
    output logic [IDX_BITS-1:0]                    err_solver,
    output logic [NUM_SOLVERS-1:0][ANSWER_BITS-1:0] answer,
    output logic [NUM_SOLVERS-1:0][CYCLE_BITS-1:0]  cycles
);
    localparam logic [IDX_BITS-1:0] LAST = IDX_BITS'(NUM_SOLVERS - 1);
    typedef struct packed {
        seq_fsm_e                                state;
        logic [IDX_BITS-1:0]                     idx;
        logic [NUM_SOLVERS-1:0]                  rel;
        seq_err_e                                err_code;
        logic [IDX_BITS-1:0]                     err_solver;
        logic [NUM_SOLVERS-1:0][ANSWER_BITS-1:0] answer;
        logic [NUM_SOLVERS-1:0][CYCLE_BITS-1:0]  cycles;
    } seq_state_t;
    seq_state_t r, n;
    logic wd_expired;
    solver_sequencer_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wd (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (r.state == S_RELEASE),
        .enable  (r.state == S_RUN),
        .expired (wd_expired)
    );
    assign busy         = r.state == S_RELEASE || r.state == S_RUN || r.state == S_GAP;
    assign done         = r.state == S_DONE;
    assign error        = r.state == S_ERROR;
    assign err_code     = r.err_code;
    assign err_solver   = r.err_solver;
    assign answer       = r.answer;
    assign cycles       = r.cycles;
    assign bus.rom_addr = r.state == S_IDLE ? '0 : bus.solver_addr[r.idx];
    assign bus.solver_rst_n = r.rel;
    always_comb begin
        n = r;
        case (r.state)
            S_IDLE, S_DONE, S_ERROR: if (start) begin
                n.state      = S_RELEASE;
                n.idx        = '0;
                n.err_code   = ERR_NONE;
                n.err_solver = '0;
                n.answer     = '0;
                n.cycles     = '0;
            end
            S_RELEASE: n.state = S_RUN;
            S_RUN: begin
                n.cycles[r.idx] = &r.cycles[r.idx] ? r.cycles[r.idx] : r.cycles[r.idx] + CYCLE_BITS'(1);
                if (bus.solver_error[r.idx]) begin
                    n.state    = S_ERROR;
                    n.err_code = ERR_SOLVER;
                end else if (bus.solver_done[r.idx]) begin
                    n.answer[r.idx] = bus.solver_answer[r.idx];
                    n.state         = S_GAP;
                end else if (wd_expired) begin
                    n.state    = S_ERROR;
                    n.err_code = ERR_TIMEOUT;
                end
            end
            S_GAP: begin
                n.state = r.idx == LAST ? S_DONE : S_RELEASE;
                n.idx   = r.idx == LAST ? r.idx : r.idx + IDX_BITS'(1);
            end
            default: ;
        endcase
        // abort overrides any same-cycle capture or advance
        if (abort && busy) begin
            n.state    = S_ERROR;
            n.idx      = r.idx;
            n.err_code = ERR_ABORT;
            n.answer   = r.answer;
        end
        if (n.state == S_ERROR && r.state != S_ERROR) n.err_solver = r.idx;
        n.rel = (n.state == S_RELEASE || n.state == S_RUN) ? NUM_SOLVERS'(1) << n.idx : '0;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r <= '0;
        else r <= n;
    end
    a_one_released: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(r.rel));
endmodule

// File: tb/tb_solver_sequencer.sv
// tb_solver_sequencer: directed table plus hand sequences against counter-based stub solvers.
module tb_solver_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic busy, done, error;
    logic [1:0] err_code;
    logic [0:0] err_solver;
    logic [1:0][47:0] answer;
    logic [1:0][31:0] cycles;
    logic [7:0] cnt [2];
    logic [7:0] done_at [2];
    logic [7:0] err_at [2];
    int total = 0;
    int bad = 0;
    always #5 clk = ~clk;
    solver_sequencer_if #(.NUM_SOLVERS(2)) bus ();
    solver_sequencer #(
        .NUM_SOLVERS(2),
        .TIMEOUT_CYCLES(16),
        .CYCLE_BITS(32)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .err_code   (err_code),
        .err_solver (err_solver),
        .answer     (answer),
        .cycles     (cycles)
    );
    // stub k counts cycles since its reset release; done/error fire at configured counts
    always_ff @(posedge clk)
        for (int i = 0; i < 2; i++) cnt[i] <= bus.solver_rst_n[i] ? cnt[i] + 8'd1 : 8'd0;
    always_comb begin
        bus.rom_data = bus.rom_addr[7:0];
        for (int i = 0; i < 2; i++) begin
            bus.solver_addr[i]   = {8'(i + 1), cnt[i]};
            bus.solver_done[i]   = bus.solver_rst_n[i] && done_at[i] != 8'd0 && cnt[i] == done_at[i];
            bus.solver_error[i]  = bus.solver_rst_n[i] && err_at[i] != 8'd0 && cnt[i] == err_at[i];
            bus.solver_answer[i] = i == 0 ? 48'd357 : 48'd168;
        end
    end
    typedef struct {
        logic [7:0]  d0, e0, d1, e1;
        int          abort_at;
        logic        exp_done;
        logic [1:0]  code;
        logic [0:0]  sol;
        logic [47:0] a0, a1;
        logic [31:0] c0, c1;
        int          lat;
    } vec_t;
    vec_t vecs [8];
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic ticks(input int k);
        for (int i = 0; i < k; i++) tick();
    endtask
    initial begin
        vecs[0] = '{8'd5, 8'd0, 8'd9, 8'd0, -1, 1'b1, 2'd0, 1'b0, 48'd357, 48'd168, 32'd5,  32'd9, 18};
        vecs[1] = '{8'd5, 8'd0, 8'd9, 8'd3, -1, 1'b0, 2'd1, 1'b1, 48'd357, 48'd0,   32'd5,  32'd3, 11};
        vecs[2] = '{8'd0, 8'd0, 8'd9, 8'd0, -1, 1'b0, 2'd2, 1'b0, 48'd0,   48'd0,   32'd16, 32'd0, 17};
        vecs[3] = '{8'd5, 8'd0, 8'd9, 8'd0, 10, 1'b0, 2'd3, 1'b1, 48'd357, 48'd0,   32'd5,  32'd3, 11};
        vecs[4] = '{8'd5, 8'd5, 8'd9, 8'd0, -1, 1'b0, 2'd1, 1'b0, 48'd0,   48'd0,   32'd5,  32'd0, 6};
        vecs[5] = '{8'd5, 8'd0, 8'd9, 8'd0, 5,  1'b0, 2'd3, 1'b0, 48'd0,   48'd0,   32'd5,  32'd0, 6};
        vecs[6] = '{8'd5, 8'd0, 8'd9, 8'd0, 6,  1'b0, 2'd3, 1'b0, 48'd357, 48'd0,   32'd5,  32'd0, 7};
        vecs[7] = '{8'd5, 8'd0, 8'd9, 8'd0, 0,  1'b0, 2'd3, 1'b0, 48'd0,   48'd0,   32'd0,  32'd0, 1};
        done_at[0] = 8'd5; done_at[1] = 8'd9;
        err_at[0] = 8'd0; err_at[1] = 8'd0;
        ticks(3);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst error", error, 0);
        chk("rst err_code", err_code, 0);
        chk("rst err_solver", err_solver, 0);
        chk("rst answer0", answer[0], 0);
        chk("rst cycles0", cycles[0], 0);
        chk("rst rom_addr", bus.rom_addr, 0);
        chk("rst solver_rst_n", bus.solver_rst_n, 0);
        rst_n = 1'b1;
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("idle abort error", error, 0);
        chk("idle abort busy", busy, 0);
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("start+abort busy", busy, 1);
        chk("release rst_n", bus.solver_rst_n, 2'b01);
        ticks(2);
        chk("run0 rom_addr", bus.rom_addr, 16'h0102);
        ticks(7);
        chk("run1 rom_addr", bus.rom_addr, 16'h0202);
        chk("run1 rst_n", bus.solver_rst_n, 2'b10);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("mid start busy", busy, 1);
        ticks(7);
        chk("pre done", done, 0);
        tick();
        chk("latency done", done, 1);
        chk("latency busy", busy, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        ticks(9);
        chk("pre reset answer0", answer[0], 357);
        chk("pre reset cycles0", cycles[0], 5);
        #2 rst_n = 1'b0;
        #1;
        chk("async busy", busy, 0);
        chk("async answer0", answer[0], 0);
        chk("async cycles0", cycles[0], 0);
        chk("async cycles1", cycles[1], 0);
        chk("async rom_addr", bus.rom_addr, 0);
        chk("async rst_n", bus.solver_rst_n, 0);
        tick();
        rst_n = 1'b1;
        tick();
        for (int v = 0; v < 8; v++) begin
            int lat;
            done_at[0] = vecs[v].d0; err_at[0] = vecs[v].e0;
            done_at[1] = vecs[v].d1; err_at[1] = vecs[v].e1;
            start = 1'b1;
            tick();
            start = 1'b0;
            lat = -1;
            for (int k = 0; k < 40 && lat < 0; k++) begin
                abort = k == vecs[v].abort_at;
                tick();
                abort = 1'b0;
                if (done || error) lat = k + 1;
            end
            chk($sformatf("v%0d latency", v), lat, vecs[v].lat);
            chk($sformatf("v%0d done", v), done, vecs[v].exp_done);
            chk($sformatf("v%0d error", v), error, !vecs[v].exp_done);
            chk($sformatf("v%0d err_code", v), err_code, vecs[v].code);
            chk($sformatf("v%0d err_solver", v), err_solver, vecs[v].sol);
            chk($sformatf("v%0d answer0", v), answer[0], vecs[v].a0);
            chk($sformatf("v%0d answer1", v), answer[1], vecs[v].a1);
            chk($sformatf("v%0d cycles0", v), cycles[0], vecs[v].c0);
            chk($sformatf("v%0d cycles1", v), cycles[1], vecs[v].c1);
            chk($sformatf("v%0d rst_n", v), bus.solver_rst_n, 0);
            chk($sformatf("v%0d busy", v), busy, 0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
